// File: rtl/mips_tb_pkg.sv
// Shared types and default addresses for the MIPS bench run monitor.
package mips_tb_pkg;

    typedef enum logic [1:0] {
        ST_HOLD,
        ST_FIRST,
        ST_RUN,
        ST_DONE
    } state_t;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'hBFC0_0000;
    localparam logic [31:0] DEFAULT_HALT_ADDR    = 32'h0000_0000;

    typedef struct packed {
        logic pass;
        logic fail;
        logic timeout;
        logic vector_error;
    } result_t;

endpackage

// File: rtl/mips_tb_stall_gen.sv
// Periodic stall pattern for the CPU clock enable; looks one cycle ahead so the
// monitor can register clk_enable.
module mips_tb_stall_gen #(
    parameter int STALL_PERIOD = 0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic run_en,
    output logic stall_next
);

    localparam bit STALL_ON = (STALL_PERIOD >= 2);
    localparam int PERIOD   = STALL_ON ? STALL_PERIOD : 2;
    localparam int CW       = $clog2(PERIOD);
    localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] cnt_next;

    // run_en is already high on the edge entering FIRST, so FIRST sees count 1.
    always_comb begin
        cnt_next = '0;
        if (run_en) begin
            cnt_next = (cnt_reg == LAST) ? '0 : cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign stall_next = STALL_ON && (cnt_next == LAST);

endmodule

// File: rtl/mips_tb_run_monitor.sv
// Run controller/checker wrapped around mips_cpu_harvard: sequences CPU reset,
// injects stalls, checks the reset vector, detects halt and grades register_v0.
module mips_tb_run_monitor
    import mips_tb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(DEFAULT_RESET_VECTOR),
    parameter logic [ADDR_W-1:0] HALT_ADDR    = ADDR_W'(DEFAULT_HALT_ADDR),
    parameter int RESET_CYCLES = 2,
    parameter int MAX_CYCLES   = 1000,
    parameter int STALL_PERIOD = 0,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic              cpu_reset,
    output logic              clk_enable,
    input  logic [ADDR_W-1:0] instr_address,
    input  logic              active,
    input  logic [DATA_W-1:0] register_v0,
    input  logic [DATA_W-1:0] expected_v0,
    input  logic [DATA_W-1:0] expected_mask,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic              timeout,
    output logic              vector_error,
    output logic [DATA_W-1:0] v0_captured,
    output logic [CNT_W-1:0]  cycle_count
);

    localparam int HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0]  MAX_CNT   = CNT_W'(MAX_CYCLES);

    state_t              state_reg;
    logic [HOLD_W-1:0]   hold_cnt_reg;
    result_t             result_reg;
    logic                done_reg;
    logic                cpu_reset_reg;
    logic                clk_enable_reg;
    logic [DATA_W-1:0]   v0_reg;
    logic [CNT_W-1:0]    count_reg;

    logic                stall_next;
    logic                run_en;
    logic                halt_seen;
    logic                v0_ok;
    logic [CNT_W-1:0]    count_inc;

    assign run_en    = (state_reg == ST_FIRST) || (state_reg == ST_RUN) ||
                       ((state_reg == ST_HOLD) && (hold_cnt_reg == HOLD_LAST));
    assign halt_seen = (instr_address == HALT_ADDR) || !active;
    assign v0_ok     = ((register_v0 ^ expected_v0) & expected_mask) == '0;
    assign count_inc = (count_reg == '1) ? count_reg : count_reg + 1'b1;

    mips_tb_stall_gen #(
        .STALL_PERIOD(STALL_PERIOD)
    ) u_stall_gen (
        .clk        (clk),
        .reset_n    (reset_n),
        .run_en     (run_en),
        .stall_next (stall_next)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= ST_HOLD;
            hold_cnt_reg   <= '0;
            result_reg     <= '0;
            done_reg       <= 1'b0;
            cpu_reset_reg  <= 1'b1;
            clk_enable_reg <= 1'b1;
            v0_reg         <= '0;
            count_reg      <= '0;
        end else begin
            case (state_reg)
                ST_HOLD: begin
                    if (hold_cnt_reg == HOLD_LAST) begin
                        state_reg      <= ST_FIRST;
                        cpu_reset_reg  <= 1'b0;
                        clk_enable_reg <= !stall_next;
                    end else begin
                        hold_cnt_reg <= hold_cnt_reg + 1'b1;
                    end
                end
                ST_FIRST: begin
                    if (!clk_enable_reg) begin
                        clk_enable_reg <= !stall_next;
                    end else begin
                        count_reg <= count_inc;
                        if (instr_address != RESET_VECTOR) begin
                            result_reg.vector_error <= 1'b1;
                            result_reg.fail         <= 1'b1;
                            done_reg                <= 1'b1;
                            clk_enable_reg          <= 1'b0;
                            state_reg               <= ST_DONE;
                        end else if (count_inc >= MAX_CNT) begin
                            result_reg.timeout <= 1'b1;
                            result_reg.fail    <= 1'b1;
                            done_reg           <= 1'b1;
                            clk_enable_reg     <= 1'b0;
                            state_reg          <= ST_DONE;
                        end else begin
                            clk_enable_reg <= !stall_next;
                            state_reg      <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (!clk_enable_reg) begin
                        clk_enable_reg <= !stall_next;
                    end else begin
                        count_reg <= count_inc;
                        // Halt is checked before the budget so a halt on the last cycle passes.
                        if (halt_seen) begin
                            v0_reg          <= register_v0;
                            result_reg.pass <= v0_ok;
                            result_reg.fail <= !v0_ok;
                            done_reg        <= 1'b1;
                            clk_enable_reg  <= 1'b0;
                            state_reg       <= ST_DONE;
                        end else if (count_inc >= MAX_CNT) begin
                            result_reg.timeout <= 1'b1;
                            result_reg.fail    <= 1'b1;
                            done_reg           <= 1'b1;
                            clk_enable_reg     <= 1'b0;
                            state_reg          <= ST_DONE;
                        end else begin
                            clk_enable_reg <= !stall_next;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign cpu_reset    = cpu_reset_reg;
    assign clk_enable   = clk_enable_reg;
    assign done         = done_reg;
    assign pass         = result_reg.pass;
    assign fail         = result_reg.fail;
    assign timeout      = result_reg.timeout;
    assign vector_error = result_reg.vector_error;
    assign v0_captured  = v0_reg;
    assign cycle_count  = count_reg;

endmodule
